// File: rtl/div_ctrl_if.sv
// Divider-side bus of div_ctrl: operand/strobe toward the RV32M divider, results and ack back.
// Signal names follow the controller's view (_o driven by div_ctrl, _i driven by the divider).
interface div_ctrl_if;
  logic        div_stb_o;
  logic [31:0] div_divident_o;
  logic [31:0] div_divisor_o;
  logic        div_is_signed_o;
  logic [31:0] div_result_i;
  logic [31:0] div_rem_i;
  logic        div_ack_i;

  modport master (
    output div_stb_o, div_divident_o, div_divisor_o, div_is_signed_o,
    input  div_result_i, div_rem_i, div_ack_i
  );

  modport slave (
    input  div_stb_o, div_divident_o, div_divisor_o, div_is_signed_o,
    output div_result_i, div_rem_i, div_ack_i
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer for the RV32M divider: local divide-by-zero/overflow resolution,
// one-entry quotient/remainder cache, and the divider stb/ack handshake.
module div_ctrl #(
  parameter int ENABLE_CACHE     = 1,
  parameter int ENABLE_FAST_PATH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  // Request handshake: stb_i is sampled only in IDLE; ack_o is a one-cycle
  // pulse with result_o valid in the same cycle; busy_o marks a divider run.
  input  logic         stb_i,
  input  logic [1:0]   op_i,
  input  logic [31:0]  rs1_i,
  input  logic [31:0]  rs2_i,
  output logic [31:0]  result_o,
  output logic         ack_o,
  output logic         busy_o,
  div_ctrl_if.master   div,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam bit CACHE_EN = (ENABLE_CACHE != 0);
  localparam bit FAST_EN  = (ENABLE_FAST_PATH != 0);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic        want_rem_q, want_rem_d;
  logic [31:0] result_q, result_d;
  logic        cache_valid_q, cache_valid_d;
  logic [31:0] key_a_q, key_a_d;
  logic [31:0] key_b_q, key_b_d;
  logic        key_signed_q, key_signed_d;
  logic [31:0] cquot_q, cquot_d;
  logic [31:0] crem_q, crem_d;

  logic req_signed;
  logic req_rem;
  logic is_div0;
  logic is_ovf;
  logic is_hit;

  assign req_signed = ~op_i[0];
  assign req_rem    = op_i[1];
  assign is_div0    = FAST_EN && (rs2_i == 32'd0);
  assign is_ovf     = FAST_EN && req_signed && (rs1_i == 32'h8000_0000) &&
                      (rs2_i == 32'hFFFF_FFFF);
  assign is_hit     = CACHE_EN && cache_valid_q && (rs1_i == key_a_q) &&
                      (rs2_i == key_b_q) && (req_signed == key_signed_q);

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    signed_d      = signed_q;
    want_rem_d    = want_rem_q;
    result_d      = result_q;
    cache_valid_d = cache_valid_q;
    key_a_d       = key_a_q;
    key_b_d       = key_b_q;
    key_signed_d  = key_signed_q;
    cquot_d       = cquot_q;
    crem_d        = crem_q;

    case (state_q)
      IDLE: begin
        if (stb_i) begin
          a_d        = rs1_i;
          b_d        = rs2_i;
          signed_d   = req_signed;
          want_rem_d = req_rem;
          if (is_div0) begin
            result_d = req_rem ? rs1_i : 32'hFFFF_FFFF;
            state_d  = RESP;
          end else if (is_ovf) begin
            result_d = req_rem ? 32'd0 : 32'h8000_0000;
            state_d  = RESP;
          end else if (is_hit) begin
            result_d = req_rem ? crem_q : cquot_q;
            state_d  = RESP;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Only a divider ack seen here is consumed; acks in other states are ignored.
        if (div.div_ack_i) begin
          key_a_d       = a_q;
          key_b_d       = b_q;
          key_signed_d  = signed_q;
          cquot_d       = div.div_result_i;
          crem_d        = div.div_rem_i;
          cache_valid_d = CACHE_EN;
          result_d      = want_rem_q ? div.div_rem_i : div.div_result_i;
          state_d       = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      signed_q      <= 1'b0;
      want_rem_q    <= 1'b0;
      result_q      <= 32'd0;
      cache_valid_q <= 1'b0;
      key_a_q       <= 32'd0;
      key_b_q       <= 32'd0;
      key_signed_q  <= 1'b0;
      cquot_q       <= 32'd0;
      crem_q        <= 32'd0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      signed_q      <= signed_d;
      want_rem_q    <= want_rem_d;
      result_q      <= result_d;
      cache_valid_q <= cache_valid_d;
      key_a_q       <= key_a_d;
      key_b_q       <= key_b_d;
      key_signed_q  <= key_signed_d;
      cquot_q       <= cquot_d;
      crem_q        <= crem_d;
    end
  end

  // Operands come straight from the capture registers so they stay stable
  // through WAIT; the divider re-reads them for its final sign correction.
  assign div.div_stb_o       = (state_q == ISSUE);
  assign div.div_divident_o  = a_q;
  assign div.div_divisor_o   = b_q;
  assign div.div_is_signed_o = signed_q;

  assign result_o    = result_q;
  assign ack_o       = (state_q == RESP);
  assign busy_o      = (state_q == ISSUE) || (state_q == WAIT);
  assign dbg_state_o = state_q;

endmodule
